// File: rtl/shift_word_receiver.sv
`default_nettype none
// ============================================================================
// Module   : shift_word_receiver
// Purpose  : Samples the MSB of an upstream parallel-load/left-shift register
//            as a serial stream, rebuilds each WIDTH-bit word, counts its ones
//            and presents the result through a one-entry valid/ready buffer
//            with sticky overrun/abort flags.
// Revision : 1.0 - initial release
// ============================================================================
module shift_word_receiver #(
  parameter int WIDTH = 6,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sdin,
  input  logic             out_ready,
  input  logic             clear_err,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    ones,
  output logic             busy,
  output logic             overrun,
  output logic             aborted
);

  localparam logic [0:0]    c_st_idle  = 1'b0;
  localparam logic [0:0]    c_st_shift = 1'b1;
  localparam logic [CW-1:0] c_last     = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_ones;
  logic             r_overrun;
  logic             r_aborted;

  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    w_pop;
  logic             w_shift;
  logic             w_done;
  logic             w_free;
  logic             w_load;
  logic             w_drop;
  logic             w_abort;

  // The word completed at this edge includes the bit being sampled now.
  assign w_word  = {r_sh[WIDTH-2:0], sdin};
  assign w_shift = (r_state == c_st_shift);
  assign w_done  = w_shift && (r_cnt == c_last);
  // A draining consumer frees the slot in the same edge a new word lands.
  assign w_free  = !r_out_valid || out_ready;
  assign w_load  = w_done && w_free;
  assign w_drop  = w_done && !w_free;
  assign w_abort = w_shift && start && !w_done;

  // Population count of the word being completed.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + {{(CW-1){1'b0}}, w_word[i]};
    end
  end

  // Capture sequencing: start/restart, bit counting and word assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state <= c_st_shift;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_sh <= w_word;
          if (w_done) begin
            // A start on the completion edge chains the next word seamlessly.
            r_state <= start ? c_st_shift : c_st_idle;
            r_cnt   <= '0;
          end else if (start) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // One-entry output buffer; data holds while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ones      <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_ones      <= w_pop;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set condition beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      if (w_drop)         r_overrun <= 1'b1;
      else if (clear_err) r_overrun <= 1'b0;
      if (w_abort)        r_aborted <= 1'b1;
      else if (clear_err) r_aborted <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign ones      = r_ones;
  assign busy      = w_shift;
  assign overrun   = r_overrun;
  assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_shift_word_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_word_receiver
// Purpose  : Self-checking bench for shift_word_receiver with an upstream
//            shift-register stimulus and a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_word_receiver;

  localparam int WIDTH = 6;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             sdin;
  logic             out_ready;
  logic             clear_err;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    ones;
  logic             busy;
  logic             overrun;
  logic             aborted;

  // Upstream parallel-load / left-shift register feeding sdin.
  logic [WIDTH-1:0] up = '0;
  assign sdin = up[WIDTH-1];

  int checks = 0;
  int errors = 0;

  // Reference model state: word-level view of the receiver.
  bit m_capturing;
  int m_nbits;
  int m_acc;
  bit m_valid;
  int m_data;
  int m_ones;
  bit m_ovr;
  bit m_abt;

  shift_word_receiver #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .sdin(sdin),
    .out_ready(out_ready), .clear_err(clear_err),
    .out_valid(out_valid), .out_data(out_data), .ones(ones),
    .busy(busy), .overrun(overrun), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_capturing = 0; m_nbits = 0; m_acc = 0;
    m_valid = 0; m_data = 0; m_ones = 0; m_ovr = 0; m_abt = 0;
  endtask

  // One clock edge of the receiver, described in terms of words collected.
  task automatic model_edge(input bit s, input bit bitin, input bit rdy, input bit clr);
    bit loaded = 0;
    bit set_o = 0;
    bit set_a = 0;
    if (m_capturing) begin
      m_acc = (m_acc * 2 + int'(bitin)) % (1 << WIDTH);
      m_nbits++;
      if (m_nbits == WIDTH) begin
        if (!m_valid || rdy) begin
          m_data = m_acc;
          m_ones = $countones(m_acc[WIDTH-1:0]);
          m_valid = 1;
          loaded = 1;
        end else begin
          set_o = 1;
        end
        m_capturing = s;
        m_nbits = 0; m_acc = 0;
      end else if (s) begin
        set_a = 1;
        m_nbits = 0; m_acc = 0;
      end
    end else if (s) begin
      m_capturing = 1;
      m_nbits = 0; m_acc = 0;
    end
    if (!loaded && rdy) m_valid = 0;
    if (clr) begin m_ovr = 0; m_abt = 0; end
    if (set_o) m_ovr = 1;
    if (set_a) m_abt = 1;
  endtask

  task automatic check_all();
    chk("valid",   32'(out_valid), 32'(m_valid));
    chk("data",    32'(out_data),  32'(m_data));
    chk("ones",    32'(ones),      32'(m_ones));
    chk("busy",    32'(busy),      32'(m_capturing));
    chk("overrun", 32'(overrun),   32'(m_ovr));
    chk("aborted", 32'(aborted),   32'(m_abt));
  endtask

  // Drive one cycle of inputs; the upstream register loads on start.
  task automatic drive(input bit s, input logic [WIDTH-1:0] d, input bit rdy, input bit clr);
    bit bit_at_edge;
    start = s; out_ready = rdy; clear_err = clr;
    bit_at_edge = sdin;
    @(posedge clk);
    @(negedge clk);
    model_edge(s, bit_at_edge, rdy, clr);
    if (s) up = d;
    else   up = up << 1;
    check_all();
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic apply_reset();
    start = 0; out_ready = 0; clear_err = 0;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_ones",  32'(ones),      32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_flags", 32'({overrun, aborted}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1; start = 0; out_ready = 0; clear_err = 0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Basic capture of 101101.
    drive(1'b1, 6'b101101, 1'b0, 1'b0);
    idle_cycles(5, 1'b0);
    chk("t1_valid_early", 32'(out_valid), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t1_data", 32'(out_data), 32'h2D);
    chk("t1_ones", 32'(ones), 32'd4);
    chk("t1_busy", 32'(busy), 32'd0);
    idle_cycles(1, 1'b1);

    // Back-to-back words with the consumer always ready.
    drive(1'b1, 6'b111111, 1'b1, 1'b0);
    idle_cycles(5, 1'b1);
    drive(1'b1, 6'b000001, 1'b1, 1'b0);
    chk("t2_data0", 32'(out_data), 32'h3F);
    chk("t2_ones0", 32'(ones), 32'd6);
    chk("t2_busy", 32'(busy), 32'd1);
    idle_cycles(5, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t2_data1", 32'(out_data), 32'h01);
    chk("t2_flags", 32'({overrun, aborted}), 32'd0);
    idle_cycles(1, 1'b1);

    // Backpressure: second word dropped, then cleared.
    drive(1'b1, 6'b010101, 1'b0, 1'b0);
    idle_cycles(5, 1'b0);
    drive(1'b1, 6'b110000, 1'b0, 1'b0);
    idle_cycles(5, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t3_data", 32'(out_data), 32'h15);
    chk("t3_overrun", 32'(overrun), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("t3_cleared", 32'(overrun), 32'd0);

    // Abort: restart at edge 3.
    drive(1'b1, 6'b101010, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);
    drive(1'b1, 6'b001111, 1'b0, 1'b0);
    chk("t4_aborted", 32'(aborted), 32'd1);
    idle_cycles(6, 1'b0);
    chk("t4_data", 32'(out_data), 32'h0F);
    chk("t4_ones", 32'(ones), 32'd4);
    drive(1'b0, '0, 1'b1, 1'b1);

    // Reset in the middle of a capture, then a fresh word.
    drive(1'b1, 6'b110011, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    apply_reset();
    drive(1'b1, 6'b100111, 1'b0, 1'b0);
    idle_cycles(6, 1'b0);
    chk("t5_data", 32'(out_data), 32'h27);

    // Drain and load on the same edge.
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 6'b100000, 1'b0, 1'b0);
    idle_cycles(5, 1'b0);
    drive(1'b1, 6'b011111, 1'b0, 1'b0);
    idle_cycles(5, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_data", 32'(out_data), 32'h1F);
    chk("t6_ones", 32'(ones), 32'd5);
    chk("t6_overrun", 32'(overrun), 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        apply_reset();
      end else begin
        drive($urandom_range(0, 6) == 0, WIDTH'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_word_receiver.md
# shift_word_receiver

- Downstream consumer of the 6-bit parallel-load / left-shift register.
- Samples that register's MSB output (q[WIDTH-1]) as a serial stream, starting from the same `start` pulse that drives the register's LD.
- Reassembles each WIDTH-bit word and counts its ones.
- Presents the result through a one-entry valid/ready output buffer, with sticky error reporting for dropped or aborted words.

## Interface

**Parameters**
- `WIDTH`, default 6: word length in bits; must match the upstream shift register.
- `CW`, default 3: width of the bit counter and ones count; must satisfy 2^CW > WIDTH.

**Ports**
- `clk`, input, 1: clock; all state changes on the rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: asserted in the same cycle as the upstream LD.
- `sdin`, input, 1: serial data; connects to the upstream q[WIDTH-1].
- `out_ready`, input, 1: the consumer accepts `out_data` when `out_ready` and `out_valid` are both 1 at an edge.
- `clear_err`, input, 1: synchronous clear of `overrun` and `aborted`.
- `out_valid`, output, 1: the output buffer holds a word.
- `out_data`, output, WIDTH: the assembled word, MSB first as received.
- `ones`, output, CW: number of 1 bits in `out_data`.
- `busy`, output, 1: a capture is in progress.
- `overrun`, output, 1: sticky; a completed word was dropped because the buffer was full.
- `aborted`, output, 1: sticky; `start` arrived during a capture.

## Operation

- **State machine:** two states, IDLE and SHIFT. The block also holds a bit counter `cnt` (CW bits), a shift register `sh` (WIDTH bits) and the output buffer.
- **Reset value of every output:** IDLE, `cnt`=0, `sh`=0, `out_valid`=0, `out_data`=0, `ones`=0, `busy`=0, `overrun`=0, `aborted`=0.
- **IDLE:** `start`=1 at an edge → SHIFT, `cnt`=0. `sdin` is ignored in IDLE.
- **SHIFT, each edge:**
  - `sh` ← {sh[WIDTH-2:0], sdin}.
  - `cnt` ← `cnt`+1.
- **Completion edge** (SHIFT with `cnt`==WIDTH-1):
  - The word is {sh[WIDTH-2:0], sdin}.
  - If the buffer is free (`out_valid`=0, or `out_ready`=1 at this edge): load `out_data` with the word, load `ones` with the popcount of the word, and set `out_valid`=1.
  - Otherwise: drop the word, leave the buffer unchanged, and set `overrun`=1.
  - Next state: SHIFT with `cnt`=0 if `start`=1 at this edge (back-to-back, no abort); otherwise IDLE.
- **`start`=1 in SHIFT with `cnt`<WIDTH-1:** discard the partial word, restart with `cnt`=0, and set `aborted`=1.
- **Buffer draining:** `out_valid` clears on an edge where `out_ready`=1 and no new word is loaded. If a drain and a load happen at the same edge, the new word replaces the old one and `out_valid` stays 1.
- **Data hold:** `out_data` and `ones` hold their value while `out_valid`=0.
- **Error flags:**
  - `clear_err`=1 clears both `overrun` and `aborted`.
  - If a set condition and `clear_err` occur at the same edge, the set wins.
- **Ones count:** `ones` is computed from the full word, with a range of 0..WIDTH.
- **`busy`:** equals (state == SHIFT).

## Timing

- `start` is sampled at edge k, and upstream loads at the same edge. Bits WIDTH-1..0 are sampled at edges k+1..k+WIDTH.
- Latency: `out_valid` rises after edge k+WIDTH, i.e. 6 cycles for the default WIDTH.
- Sustained throughput: one word every WIDTH cycles, with `start` coinciding with each completion edge. No bubble, no error.
- `busy` is 1 from after edge k until after the completion edge. It stays 1 if a back-to-back `start` arrives.
- Asynchronous `reset` mid-capture or with `out_valid`=1 returns every output to its reset value immediately. The partial word is lost, and no flag is set.
- `out_ready` has no effect while `out_valid`=0.

## Test plan

1. **Basic capture:** reset, then `start` at edge 0, with `sdin` driven by the upstream register loaded with 101101. → `out_valid`=1 after edge 6, `out_data`=101101, `ones`=4, `busy` low after edge 6.
2. **Back-to-back:** load 111111, then 000001, with `start` at edges 0 and 6 and `out_ready`=1 throughout. → Words 111111 (`ones`=6) and 000001 (`ones`=1) appear after edges 6 and 12; `overrun`=0, `aborted`=0.
3. **Backpressure:** `out_ready`=0, and two words 010101 and 110000 are captured back-to-back. → `out_data` holds 010101; `overrun`=1 after edge 12. Then pulse `clear_err` → `overrun`=0.
4. **Abort:** `start` at edge 0 with 101010, then `start` again at edge 3 with 001111. → `aborted`=1 after edge 3; a single word 001111 after edge 9, with `ones`=4.
5. **Reset mid-capture:** `reset` asserted between edges 3 and 4. → All outputs read 0 immediately. A new `start` then produces a correct word 6 edges later.
6. **Drain/load collision:** `out_valid`=1 with 100000, and `out_ready`=1 on the completion edge of 011111. → `out_valid` stays 1, `out_data`=011111, `ones`=5, no `overrun`.
